// File: rtl/adxl_spi_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adxl_spi_responder : ADXL362 register-interface emulator (SPI mode 0 slave, oversampled), rev 1.0
// Define ADXL_RESP_STATUS_EN to add the STATUS register at 0x0B (bit0 = DATA_READY).
// ---------------------------------------------------------------------------
module adxl_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID_AD    = 8'hAD,
    parameter logic [7:0]  DEVID_MST   = 8'h1D,
    parameter logic [7:0]  PART_ID     = 8'hF2
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       sclk,
    input  logic       csn_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic       sample_valid,
    input  logic [7:0] sample_x,
    input  logic [7:0] sample_y,
    input  logic [7:0] sample_z,
    output logic [7:0] power_ctl,
    output logic [7:0] filter_ctl,
    output logic       wr_strobe,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_IGNORE
    } state_t;

    localparam logic [7:0] c_cmd_read    = 8'h0B;
    localparam logic [7:0] c_cmd_write   = 8'h0A;
    localparam logic [5:0] c_addr_x      = 6'h08;
    localparam logic [5:0] c_addr_filter = 6'h2C;
    localparam logic [5:0] c_addr_power  = 6'h2D;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] csn_sync_q,  csn_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   csn_prev_q,  csn_prev_d;

    state_t     state_q,     state_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [6:0] rx_q,        rx_d;
    logic [7:0] tx_q,        tx_d;
    logic [5:0] addr_q,      addr_d;
    logic       is_read_q,   is_read_d;
    logic       miso_q,      miso_d;
    logic       miso_oe_q,   miso_oe_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [5:0] wr_addr_q,   wr_addr_d;
    logic [7:0] wr_data_q,   wr_data_d;
    logic [7:0] power_q,     power_d;
    logic [7:0] filter_q,    filter_d;

    logic [7:0] shadow_x_q, shadow_x_d;
    logic [7:0] shadow_y_q, shadow_y_d;
    logic [7:0] shadow_z_q, shadow_z_d;
    logic [7:0] pend_x_q,   pend_x_d;
    logic [7:0] pend_y_q,   pend_y_d;
    logic [7:0] pend_z_q,   pend_z_d;
    logic       pend_valid_q, pend_valid_d;

    logic       sclk_s, csn_s, mosi_s;
    logic       sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic       active, byte_end;
    logic [7:0] rx_byte;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] status_byte;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0],  csn_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
        csn_prev_d  = csn_sync_q[SYNC_STAGES-1];
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign csn_rise  = csn_s & ~csn_prev_q;
    assign csn_fall  = ~csn_s & csn_prev_q;

    assign active   = ~csn_s & (state_q != ST_IDLE);
    assign rx_byte  = {rx_q, mosi_s};
    assign byte_end = active & sclk_rise & (bit_cnt_q == 3'd7);

`ifdef ADXL_RESP_STATUS_EN
    logic data_ready_q, data_ready_d;
    logic status_clr, shadow_upd;

    assign status_clr = byte_end & (state_q == ST_RD_DATA) & (addr_q == c_addr_x);
    assign shadow_upd = (sample_valid & csn_s) | (csn_rise & pend_valid_q);

    // Set has priority so a fresh sample is never reported as stale.
    always_comb begin
        data_ready_d = data_ready_q;
        if (status_clr) data_ready_d = 1'b0;
        if (shadow_upd) data_ready_d = 1'b1;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) data_ready_q <= 1'b0;
        else         data_ready_q <= data_ready_d;
    end

    assign status_byte = {7'd0, data_ready_q};
`else
    assign status_byte = 8'h00;
`endif

    // The address byte selects the first register; later bytes preload addr+1.
    always_comb begin
        rd_addr = (state_q == ST_ADDR) ? rx_byte[5:0] : addr_q + 6'd1;
        case (rd_addr)
            6'h00:         rd_data = DEVID_AD;
            6'h01:         rd_data = DEVID_MST;
            6'h02:         rd_data = PART_ID;
            6'h08:         rd_data = shadow_x_q;
            6'h09:         rd_data = shadow_y_q;
            6'h0A:         rd_data = shadow_z_q;
            6'h0B:         rd_data = status_byte;
            c_addr_filter: rd_data = filter_q;
            c_addr_power:  rd_data = power_q;
            default:       rd_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        is_read_d   = is_read_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        power_d     = power_q;
        filter_d    = filter_q;

        if (csn_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (csn_fall) begin
                state_d   = ST_CMD;
                bit_cnt_d = 3'd0;
                rx_d      = 7'd0;
            end
        end else if (active) begin
            if (sclk_rise) begin
                rx_d      = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (sclk_fall && (state_q == ST_RD_DATA)) begin
                miso_d    = tx_q[7];
                tx_d      = {tx_q[6:0], 1'b0};
                miso_oe_d = 1'b1;
            end
            if (byte_end) begin
                case (state_q)
                    ST_CMD: begin
                        if (rx_byte == c_cmd_read) begin
                            state_d   = ST_ADDR;
                            is_read_d = 1'b1;
                        end else if (rx_byte == c_cmd_write) begin
                            state_d   = ST_ADDR;
                            is_read_d = 1'b0;
                        end else begin
                            state_d   = ST_IGNORE;
                        end
                    end
                    ST_ADDR: begin
                        addr_d  = rx_byte[5:0];
                        tx_d    = rd_data;
                        state_d = is_read_q ? ST_RD_DATA : ST_WR_DATA;
                    end
                    ST_RD_DATA: begin
                        addr_d = addr_q + 6'd1;
                        tx_d   = rd_data;
                    end
                    ST_WR_DATA: begin
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = addr_q;
                        wr_data_d   = rx_byte;
                        if (addr_q == c_addr_filter) filter_d = rx_byte;
                        if (addr_q == c_addr_power)  power_d  = rx_byte;
                        addr_d = addr_q + 6'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Samples arriving mid-transaction are parked so a burst never mixes two samples.
    always_comb begin
        shadow_x_d   = shadow_x_q;
        shadow_y_d   = shadow_y_q;
        shadow_z_d   = shadow_z_q;
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        pend_z_d     = pend_z_q;
        pend_valid_d = pend_valid_q;

        if (sample_valid && csn_s) begin
            shadow_x_d   = sample_x;
            shadow_y_d   = sample_y;
            shadow_z_d   = sample_z;
            pend_valid_d = 1'b0;
        end else begin
            if (sample_valid) begin
                pend_x_d     = sample_x;
                pend_y_d     = sample_y;
                pend_z_d     = sample_z;
                pend_valid_d = 1'b1;
            end
            if (csn_rise && pend_valid_q) begin
                shadow_x_d   = pend_x_q;
                shadow_y_d   = pend_y_q;
                shadow_z_d   = pend_z_q;
                pend_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sclk_sync_q  <= '0;
            csn_sync_q   <= '1;
            mosi_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            csn_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            rx_q         <= 7'd0;
            tx_q         <= 8'h00;
            addr_q       <= 6'd0;
            is_read_q    <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= 6'd0;
            wr_data_q    <= 8'h00;
            power_q      <= 8'h00;
            filter_q     <= 8'h13;
            shadow_x_q   <= 8'h00;
            shadow_y_q   <= 8'h00;
            shadow_z_q   <= 8'h00;
            pend_x_q     <= 8'h00;
            pend_y_q     <= 8'h00;
            pend_z_q     <= 8'h00;
            pend_valid_q <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            csn_sync_q   <= csn_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            csn_prev_q   <= csn_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            addr_q       <= addr_d;
            is_read_q    <= is_read_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            power_q      <= power_d;
            filter_q     <= filter_d;
            shadow_x_q   <= shadow_x_d;
            shadow_y_q   <= shadow_y_d;
            shadow_z_q   <= shadow_z_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pend_z_q     <= pend_z_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = miso_oe_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign power_ctl  = power_q;
    assign filter_ctl = filter_q;

endmodule
`default_nettype wire

// File: tb/tb_adxl_spi_responder.sv
`default_nettype none
// tb_adxl_spi_responder: SPI-master stimulus with a register-map reference model and a bus-level scoreboard.
module tb_adxl_spi_responder;

    localparam int HALF      = 6;
    localparam int IDLE_CLKS = 14;
`ifdef ADXL_RESP_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       arst_n;
    logic       sclk, csn_n, mosi;
    logic       miso, miso_oe;
    logic       sample_valid;
    logic [7:0] sample_x, sample_y, sample_z;
    logic [7:0] power_ctl, filter_ctl;
    logic       wr_strobe;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    always #5 clk = ~clk;

    adxl_spi_responder dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .sclk         (sclk),
        .csn_n        (csn_n),
        .mosi         (mosi),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .sample_valid (sample_valid),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .sample_z     (sample_z),
        .power_ctl    (power_ctl),
        .filter_ctl   (filter_ctl),
        .wr_strobe    (wr_strobe),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    bit          started  = 1'b0;
    logic [7:0]  exp_rd[$];
    logic [13:0] exp_wr[$];

    // Reference model of the visible register state.
    logic [7:0] m_x, m_y, m_z, m_px, m_py, m_pz, m_filter, m_power;
    logic       m_pend, m_dr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [5:0] a);
        case (a)
            6'h00:   return 8'hAD;
            6'h01:   return 8'h1D;
            6'h02:   return 8'hF2;
            6'h08:   return m_x;
            6'h09:   return m_y;
            6'h0A:   return m_z;
            6'h0B:   return STATUS_EN ? {7'd0, m_dr} : 8'h00;
            6'h2C:   return m_filter;
            6'h2D:   return m_power;
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_reset();
        m_x = 8'h00; m_y = 8'h00; m_z = 8'h00;
        m_px = 8'h00; m_py = 8'h00; m_pz = 8'h00;
        m_filter = 8'h13; m_power = 8'h00;
        m_pend = 1'b0; m_dr = 1'b0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            wait_clks(HALF);
            sclk = 1'b1;
            wait_clks(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic start_txn();
        csn_n = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic end_txn();
        wait_clks(HALF);
        csn_n = 1'b1;
        if (m_pend) begin
            m_x = m_px; m_y = m_py; m_z = m_pz;
            m_pend = 1'b0;
            m_dr = 1'b1;
        end
        wait_clks(IDLE_CLKS);
    endtask

    task automatic pulse_sample(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                                input bit idle);
        sample_valid = 1'b1;
        sample_x = x; sample_y = y; sample_z = z;
        wait_clks(1);
        sample_valid = 1'b0;
        sample_x = 8'($urandom); sample_y = 8'($urandom); sample_z = 8'($urandom);
        if (idle) begin
            m_x = x; m_y = y; m_z = z;
            m_dr = 1'b1;
            wait_clks(3);
        end else begin
            m_px = x; m_py = y; m_pz = z;
            m_pend = 1'b1;
        end
    endtask

    task automatic do_read(input logic [5:0] start, input int len, input bit mid,
                           input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] sz);
        logic [5:0] a;
        start_txn();
        spi_bits(8'h0B, 8);
        if (mid) pulse_sample(sx, sy, sz, 1'b0);
        spi_bits({2'($urandom), start}, 8);
        a = start;
        for (int k = 0; k < len; k++) begin
            exp_rd.push_back(m_read(a));
            if (a == 6'h08) m_dr = 1'b0;
            spi_bits(8'($urandom), 8);
            a = a + 6'd1;
        end
        end_txn();
    endtask

    task automatic do_write(input logic [5:0] start, input logic [7:0] d [4], input int len,
                            input int trunc);
        logic [5:0] a;
        start_txn();
        spi_bits(8'h0A, 8);
        spi_bits({2'($urandom), start}, 8);
        a = start;
        for (int k = 0; k < len; k++) begin
            exp_wr.push_back({a, d[k]});
            if (a == 6'h2C) m_filter = d[k];
            if (a == 6'h2D) m_power  = d[k];
            spi_bits(d[k], 8);
            a = a + 6'd1;
        end
        if (trunc > 0) spi_bits(8'($urandom), trunc);
        end_txn();
        chk("filter_ctl", filter_ctl, m_filter);
        chk("power_ctl", power_ctl, m_power);
    endtask

    // Bus monitor: decodes each byte as the master sees it and checks read data and miso_oe.
    logic [7:0] mon_mosi = 8'h00, mon_miso = 8'h00, mon_cmd = 8'h00, mon_exp;
    int         mon_bit = 0, mon_byte = 0;
    logic       oe_bad = 1'b0;

    always @(posedge sclk or negedge csn_n) begin
        if (!sclk) begin
            mon_bit = 0; mon_byte = 0; mon_cmd = 8'h00; oe_bad = 1'b0;
        end else if (!csn_n && started) begin
            mon_mosi = {mon_mosi[6:0], mosi};
            mon_miso = {mon_miso[6:0], miso};
            if (miso_oe !== ((mon_byte >= 2) && (mon_cmd == 8'h0B))) oe_bad = 1'b1;
            mon_bit++;
            if (mon_bit == 8) begin
                chk("miso_oe_in_byte", oe_bad, 1'b0);
                if (mon_byte == 0) begin
                    mon_cmd = mon_mosi;
                end else if ((mon_cmd == 8'h0B) && (mon_byte >= 2)) begin
                    if (exp_rd.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL miso_byte: got 0x%0h, expected no read byte", mon_miso);
                    end else begin
                        mon_exp = exp_rd.pop_front();
                        chk("miso_byte", mon_miso, mon_exp);
                    end
                end
                mon_bit = 0;
                mon_byte++;
                oe_bad = 1'b0;
            end
        end
    end

    logic [13:0] wr_exp;
    always @(negedge clk) begin
        if (started && (wr_strobe === 1'b1)) begin
            if (exp_wr.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL wr_strobe: got addr 0x%0h data 0x%0h, expected no pulse", wr_addr, wr_data);
            end else begin
                wr_exp = exp_wr.pop_front();
                chk("wr_addr_data", {wr_addr, wr_data}, wr_exp);
            end
        end
    end

    always @(posedge csn_n) begin
        if (started) begin
            wait_clks(6);
            chk("miso_idle_after_csn", {miso_oe, miso}, 2'b00);
        end
    end

    initial begin
        repeat (80000) @(negedge clk);
        $display("FAIL watchdog: got no finish, expected finish within 80000 cycles");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] d [4];
    logic [5:0] wstart;
    logic [7:0] jcmd;
    int         op, sel;

    initial begin
        arst_n = 1'b0; sclk = 1'b0; csn_n = 1'b1; mosi = 1'b0;
        sample_valid = 1'b0; sample_x = 8'h00; sample_y = 8'h00; sample_z = 8'h00;
        m_reset();
        wait_clks(4);
        arst_n = 1'b1;
        wait_clks(4);
        started = 1'b1;

        chk("rst_miso", miso, 1'b0);
        chk("rst_miso_oe", miso_oe, 1'b0);
        chk("rst_wr_strobe", wr_strobe, 1'b0);
        chk("rst_wr_addr", wr_addr, 6'd0);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_power_ctl", power_ctl, 8'h00);
        chk("rst_filter_ctl", filter_ctl, 8'h13);

        // ID registers, then shadows latched while idle.
        do_read(6'h00, 3, 1'b0, 8'h00, 8'h00, 8'h00);
        pulse_sample(8'h12, 8'hF4, 8'h40, 1'b1);
        do_read(6'h08, 3, 1'b0, 8'h00, 8'h00, 8'h00);
        // A sample during a burst must not leak into it.
        do_read(6'h08, 3, 1'b1, 8'h55, 8'h66, 8'h77);
        do_read(6'h08, 1, 1'b0, 8'h00, 8'h00, 8'h00);

        d[0] = 8'h93; d[1] = 8'h02; d[2] = 8'h00; d[3] = 8'h00;
        do_write(6'h2C, d, 2, 0);
        d[0] = 8'h77;
        do_write(6'h00, d, 1, 0);
        do_read(6'h00, 1, 1'b0, 8'h00, 8'h00, 8'h00);
        do_write(6'h2D, d, 0, 4);
        do_read(6'h3F, 2, 1'b0, 8'h00, 8'h00, 8'h00);

        // DATA_READY set, read, clear, and re-set by a sample parked during the clearing read.
        pulse_sample(8'h21, 8'h22, 8'h23, 1'b1);
        do_read(6'h0B, 1, 1'b0, 8'h00, 8'h00, 8'h00);
        do_read(6'h08, 1, 1'b0, 8'h00, 8'h00, 8'h00);
        do_read(6'h0B, 1, 1'b0, 8'h00, 8'h00, 8'h00);
        do_read(6'h08, 1, 1'b1, 8'h31, 8'h32, 8'h33);
        do_read(6'h0B, 1, 1'b0, 8'h00, 8'h00, 8'h00);
        do_read(6'h08, 4, 1'b0, 8'h00, 8'h00, 8'h00);

        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: do_read(6'($urandom), $urandom_range(1, 4), 1'($urandom),
                           8'($urandom), 8'($urandom), 8'($urandom));
                1, 4: begin
                    for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
                    sel = $urandom_range(0, 3);
                    wstart = (sel == 0) ? 6'h2C : (sel == 1) ? 6'h2D : (sel == 2) ? 6'h2B : 6'($urandom);
                    do_write(wstart, d, $urandom_range(1, 3),
                             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
                end
                2: pulse_sample(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
                3: do_read(6'h08, 4, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                default: begin
                    jcmd = 8'($urandom);
                    while ((jcmd == 8'h0A) || (jcmd == 8'h0B)) jcmd = 8'($urandom);
                    start_txn();
                    spi_bits(jcmd, 8);
                    spi_bits(8'h2C, 8);
                    spi_bits(8'($urandom), 8);
                    end_txn();
                end
            endcase
        end

        // Asynchronous reset in the middle of a read data byte.
        d[0] = 8'h5A; d[1] = 8'h03;
        do_write(6'h2C, d, 2, 0);
        start_txn();
        spi_bits(8'h0B, 8);
        spi_bits(8'h08, 8);
        spi_bits(8'hFF, 3);
        wait_clks(2);
        chk("oe_before_reset", miso_oe, 1'b1);
        arst_n = 1'b0;
        #1;
        chk("arst_miso_oe", miso_oe, 1'b0);
        chk("arst_miso", miso, 1'b0);
        chk("arst_filter_ctl", filter_ctl, 8'h13);
        chk("arst_power_ctl", power_ctl, 8'h00);
        chk("arst_wr_addr_data", {wr_addr, wr_data}, 14'd0);
        csn_n = 1'b1;
        m_reset();
        wait_clks(4);
        arst_n = 1'b1;
        wait_clks(IDLE_CLKS);
        do_read(6'h08, 3, 1'b0, 8'h00, 8'h00, 8'h00);
        do_read(6'h2C, 2, 1'b0, 8'h00, 8'h00, 8'h00);

        wait_clks(20);
        chk("read_queue_drained", exp_rd.size(), 0);
        chk("write_queue_drained", exp_wr.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
